led_pattern_sequencer: RTL and testbench
========================================

// Module: led_pattern_sequencer
// PURPOSE
//  Controller that sequences the 16-LED bank: prescales clk into step ticks and runs one of
//  four display patterns (chase, bounce, blink, fill) under run/pause/clear control.
//  Sits between board switches/buttons and the led pins; replaces hand-driven led stimulus.
// PARAMETERS
//  N_LEDS    16          number of LEDs driven (>= 2)
//  TICK_DIV  10_000_000  clk cycles per pattern step (>= 2); 10 Hz at 100 MHz
//  PWM_BITS  4           brightness resolution (used only with LED_PWM_EN)
// PORTS
//  clk         in   1         system clock; single clock domain
//  reset       in   1         synchronous, active-high; overrides all other inputs
//  enable      in   1         level: 1 = run, 0 = pause
//  clear       in   1         pulse: return to IDLE, LEDs off
//  mode        in   2         pattern select: 0 CHASE, 1 BOUNCE, 2 BLINK, 3 FILL
//  mode_load   in   1         pulse: latch mode and restart pattern
//  brightness  in   PWM_BITS  duty level; ignored without LED_PWM_EN
//  led         out  N_LEDS    LED drive, registered
//  step        out  1         one-cycle pulse, coincident with each pattern advance
//  busy        out  1         1 when state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, mode_q=CHASE, dir=up, prescaler=0, led=0, step=0, busy=0, pwm_cnt=0.
//  Priority per cycle: reset > clear > mode_load > enable.
//  States: IDLE (led=0, prescaler held at 0), RUN (prescaler counts), HOLD (led and prescaler frozen).
//  IDLE, enable=1 -> RUN next cycle. led=initial pattern, prescaler=0.
//  Initial patterns: CHASE/BOUNCE/FILL 'h0001, BLINK all-ones.
//  RUN, enable=0 -> HOLD. HOLD, enable=1 -> RUN. Prescaler count preserved across the pause.
//  clear in any state -> IDLE next cycle, led=0, dir=up. mode_q kept. A same-cycle mode_load is dropped.
//  mode_load: mode_q<=mode in all states. In RUN/HOLD also reload initial pattern, prescaler=0, dir=up.
//   State is unchanged, except mode_load with enable=0 in RUN -> HOLD.
//  Prescaler: 0..TICK_DIV-1, wraps. At TICK_DIV-1 in RUN, next cycle led advances and step=1.
//   First advance appears TICK_DIV cycles after the initial pattern.
//  CHASE: rotate left by 1; bit N-1 wraps to bit 0.
//  BOUNCE: shift toward current dir. At bit N-1 (dir up) dir flips, next is bit N-2; symmetric at bit 0.
//   End LEDs are lit for one step each.
//  BLINK: invert all bits each step.
//  FILL: led <= {led[N-2:0],1'b1}. When all-ones, next step is 0, then 'h0001.
//  No step pulses in IDLE/HOLD or on a mode_load cycle. Reset mid-run aborts immediately, no partial step.
// CONFIGURATION
//  LED_PWM_EN defined:
//   Free-running PWM_BITS counter pwm_cnt, unaffected by state.
//   led = pattern & {N_LEDS{pwm_cnt < brightness}}, registered. brightness=0 -> dark.
//   Max duty (2^PWM_BITS-1)/2^PWM_BITS.
//  LED_PWM_EN undefined: led = pattern, no pwm_cnt, brightness unused.
// STRUCTURE
//  Package led_pkg: mode_e enum (MODE_CHASE, MODE_BOUNCE, MODE_BLINK, MODE_FILL),
//   seq_state_e (IDLE, RUN, HOLD), and initial-pattern constants.
//  One sub-module, led_tick_prescaler (TICK_DIV; inputs run, restart; output tick).
//  FSM, pattern register and PWM stay in this module.
// TESTING (bench uses TICK_DIV=4, N_LEDS=16)
//  1 reset; mode_load mode=0; enable=1
//    -> led 0001 next cycle, 0002 four cycles later, ... 8000 -> 0001; step every 4 cycles; busy=1
//  2 mode=BOUNCE
//    -> 4000,8000,4000,2000 ... 0002,0001,0002; no repeated end value
//  3 mode=FILL
//    -> 0001,0003,0007 ... FFFF,0000,0001; BLINK -> FFFF,0000,FFFF
//  4 enable=0 for 10 cycles, 2 cycles after a step
//    -> led frozen, step=0; on re-enable the next advance comes 2 cycles later
//  5 mode_load mode=BLINK while led=0010
//    -> FFFF next cycle, step=0, 0000 after 4 cycles
//    -> then clear+mode_load same cycle: IDLE, led=0, busy=0, mode_q unchanged; reset mid-run -> all reset values
//  6 LED_PWM_EN, brightness=4, CHASE held
//    -> led bit on exactly 4 of every 16 cycles; brightness=0 -> led=0 throughout

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_CHASE  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } seq_state_e;

    // Shape of the pattern loaded when a mode starts.
    typedef enum logic {
        INIT_SINGLE = 1'b0, // only bit 0 lit
        INIT_ALL_ON = 1'b1  // every LED lit
    } init_kind_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic init_kind_e init_kind(input mode_e m);
        return (m == MODE_BLINK) ? INIT_ALL_ON : INIT_SINGLE;
    endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Divides clk into one-cycle step ticks every TICK_DIV counted cycles.
// The count is held while run is low and forced to zero by restart.
module led_tick_prescaler #(
    parameter int unsigned TICK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count and terminal-count tick; restart wins over run.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (restart) begin
            cnt_d = '0;
        end else if (run) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// 16-LED bank sequencer: chase, bounce, blink and fill patterns under
// run/pause/clear control. Optional brightness PWM when LED_PWM_EN is defined.
module led_pattern_sequencer
    import led_pkg::*;
#(
    parameter int unsigned N_LEDS   = 16,
    parameter int unsigned TICK_DIV = 10_000_000,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear,
    input  logic [1:0]          mode,
    input  logic                mode_load,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [N_LEDS-1:0]   led,
    output logic                step,
    output logic                busy
);

    localparam logic [N_LEDS-1:0] PAT_SINGLE = {{(N_LEDS-1){1'b0}}, 1'b1};
    localparam logic [N_LEDS-1:0] PAT_ALL_ON = {N_LEDS{1'b1}};

    seq_state_e        state_q, state_d;
    mode_e             mode_q, mode_d;
    logic              dir_q, dir_d;
    logic [N_LEDS-1:0] pat_q, pat_d;
    logic              step_q;

    logic              tick, restart, run;
    logic [N_LEDS-1:0] pat_next;
    logic              dir_next;
    logic [N_LEDS-1:0] init_new, init_cur;

    assign init_new = (init_kind(mode_e'(mode)) == INIT_ALL_ON) ? PAT_ALL_ON : PAT_SINGLE;
    assign init_cur = (init_kind(mode_q) == INIT_ALL_ON) ? PAT_ALL_ON : PAT_SINGLE;

    // Prescaler sits at zero in IDLE and restarts on clear or a pattern reload.
    // It counts on every enabled cycle outside IDLE, including the HOLD->RUN
    // cycle, so a pause costs exactly the cycles spent paused.
    assign restart = (state_q == IDLE) || clear || mode_load;
    assign run     = enable && (state_q != IDLE);

    led_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .restart (restart),
        .tick    (tick)
    );

    // Pattern advance for the latched mode.
    always_comb begin
        pat_next = pat_q;
        dir_next = dir_q;
        case (mode_q)
            MODE_CHASE:  pat_next = {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
            MODE_BOUNCE: begin
                if (dir_q == DIR_UP) begin
                    if (pat_q[N_LEDS-1]) begin
                        pat_next = pat_q >> 1;
                        dir_next = DIR_DOWN;
                    end else begin
                        pat_next = pat_q << 1;
                    end
                end else begin
                    if (pat_q[0]) begin
                        pat_next = pat_q << 1;
                        dir_next = DIR_UP;
                    end else begin
                        pat_next = pat_q >> 1;
                    end
                end
            end
            MODE_BLINK:  pat_next = ~pat_q;
            MODE_FILL:   pat_next = (&pat_q) ? '0 : {pat_q[N_LEDS-2:0], 1'b1};
            default:     pat_next = pat_q;
        endcase
    end

    // Control FSM: clear > mode_load > enable.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        pat_d   = pat_q;
        if (clear) begin
            state_d = IDLE;
            pat_d   = '0;
            dir_d   = DIR_UP;
        end else if (mode_load) begin
            mode_d = mode_e'(mode);
            if (state_q != IDLE) begin
                pat_d = init_new;
                dir_d = DIR_UP;
                if (state_q == RUN && !enable) begin
                    state_d = HOLD;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_d = RUN;
                        pat_d   = init_cur;
                        dir_d   = DIR_UP;
                    end
                end
                RUN:     if (!enable) state_d = HOLD;
                HOLD:    if (enable) state_d = RUN;
                default: state_d = IDLE;
            endcase
            // tick is already suppressed on clear/mode_load cycles
            if (tick) begin
                pat_d = pat_next;
                dir_d = dir_next;
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= MODE_CHASE;
            dir_q   <= DIR_UP;
            pat_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            pat_q   <= pat_d;
            step_q  <= tick;
        end
    end

    assign step = step_q;
    assign busy = (state_q != IDLE);

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [N_LEDS-1:0]   led_q, led_d;

    // Free-running duty counter and gated LED drive.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        led_d     = pat_d & {N_LEDS{pwm_cnt_q < brightness}};
    end

    // PWM counter and LED output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q <= '0;
            led_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    assign led = led_q;
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign led = pat_q;
`endif

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomized + directed bench for led_pattern_sequencer (N_LEDS=16, TICK_DIV=4).
// The reference model tracks step index per mode and derives the LED value
// arithmetically. Define LED_PWM_EN to also exercise the brightness gate.
module tb_led_pattern_sequencer;

    localparam int unsigned N_LEDS   = 16;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned PWM_BITS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        mode_load = 1'b0;
    logic [3:0]  brightness = 4'd0;
    logic [15:0] led;
    logic        step;
    logic        busy;

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .N_LEDS   (N_LEDS),
        .TICK_DIV (TICK_DIV),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .mode       (mode),
        .mode_load  (mode_load),
        .brightness (brightness),
        .led        (led),
        .step       (step),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: 0 idle, 1 run, 2 hold; k = steps taken since the pattern started.
    int m_state = 0;
    int m_mode  = 0;
    int m_k     = 0;
    int m_cnt   = 0;
    bit m_step  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] pattern_of(input int md, input int k);
        int p;
        logic [31:0] v;
        case (md)
            0: v = 32'd1 << (k % 16);
            1: begin
                p = k % 30;
                v = 32'd1 << ((p <= 15) ? p : 30 - p);
            end
            2: v = (k % 2 == 0) ? 32'hFFFF : 32'h0;
            default: begin
                p = k % 17;
                v = (p == 16) ? 32'h0 : (32'd1 << (p + 1)) - 32'd1;
            end
        endcase
        return v[15:0];
    endfunction

    function automatic logic [15:0] exp_led();
        return (m_state == 0) ? 16'h0 : pattern_of(m_mode, m_k);
    endfunction

    task automatic model_update();
        m_step = 0;
        if (reset) begin
            m_state = 0; m_mode = 0; m_k = 0; m_cnt = 0;
        end else if (clear) begin
            m_state = 0; m_k = 0; m_cnt = 0;
        end else if (mode_load) begin
            m_mode = int'(mode);
            if (m_state != 0) begin
                m_k = 0; m_cnt = 0;
                if (m_state == 1 && !enable) m_state = 2;
            end
        end else if (enable) begin
            if (m_state == 0) begin
                m_state = 1; m_k = 0; m_cnt = 0;
            end else begin
                m_state = 1;
                m_cnt++;
                if (m_cnt == int'(TICK_DIV)) begin
                    m_cnt = 0; m_k++; m_step = 1;
                end
            end
        end else if (m_state == 1) begin
            m_state = 2;
        end
    endtask

    // One clock: DUT and model advance on the same inputs, outputs checked #1 later.
    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
`ifndef LED_PWM_EN
        check_val("led", 32'(led), 32'(exp_led()));
`endif
        check_val("step", 32'(step), 32'(m_step));
        check_val("busy", 32'(busy), 32'(m_state != 0));
    endtask

    task automatic load_mode(input logic [1:0] md);
        mode = md; mode_load = 1'b1;
        cycle();
        mode_load = 1'b0;
    endtask

    initial begin
        int n;
        bit found;
        int lit;

        // Reset
        reset = 1'b1;
        cycle(); cycle();
        check_val("reset_led", 32'(led), 32'h0);
        reset = 1'b0;

        // CHASE through a full wrap
        load_mode(2'd0);
        enable = 1'b1;
        repeat (70) cycle();

        // BOUNCE, FILL, BLINK, each loaded while running
        load_mode(2'd1);
        repeat (130) cycle();
        load_mode(2'd3);
        repeat (80) cycle();
        load_mode(2'd2);
        repeat (20) cycle();

        // Pause two cycles after a step; resume must finish the remaining two counts
        load_mode(2'd0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            found = step;
        end
        check_val("step_seen", 32'(found), 32'd1);
        cycle(); cycle();
        enable = 1'b0;
        repeat (10) cycle();
        enable = 1'b1;
        n = 0; found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            n++;
            found = step;
        end
        check_val("resume_latency", 32'(n), 32'd2);

        // Reload BLINK when CHASE shows 0010
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            cycle();
            found = (led == 16'h0010);
        end
`ifndef LED_PWM_EN
        check_val("find_0010", 32'(found), 32'd1);
`endif
        load_mode(2'd2);
`ifndef LED_PWM_EN
        check_val("blink_load", 32'(led), 32'hFFFF);
`endif
        check_val("blink_load_step", 32'(step), 32'd0);
        repeat (4) cycle();
`ifndef LED_PWM_EN
        check_val("blink_first_step", 32'(led), 32'h0000);
`endif

        // clear + mode_load together: mode_load dropped, mode stays BLINK
        clear = 1'b1; mode = 2'd0; mode_load = 1'b1;
        cycle();
        clear = 1'b0; mode_load = 1'b0;
        check_val("clear_busy", 32'(busy), 32'd0);
        check_val("clear_led", 32'(led), 32'h0);
        cycle();
`ifndef LED_PWM_EN
        check_val("mode_kept", 32'(led), 32'hFFFF);
`endif
        repeat (6) cycle();

        // Reset mid-run
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_val("midrun_reset_busy", 32'(busy), 32'd0);
        repeat (3) cycle();

        // Random control traffic
        for (int i = 0; i < 800; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            clear     = ($urandom_range(0, 49) == 0);
            mode_load = ($urandom_range(0, 29) == 0);
            mode      = 2'($urandom_range(0, 3));
            enable    = ($urandom_range(0, 9) != 0);
            cycle();
        end
        reset = 1'b0; clear = 1'b0; mode_load = 1'b0;

`ifdef LED_PWM_EN
        // CHASE frozen at 0001 in HOLD; duty gated by brightness
        reset = 1'b1; cycle(); reset = 1'b0;
        load_mode(2'd0);
        enable = 1'b1; cycle();
        enable = 1'b0; cycle();
        brightness = 4'd4;
        cycle();
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (led[0]) lit++;
        end
        check_val("pwm_duty4", 32'(lit), 32'd4);
        brightness = 4'd0;
        cycle();
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (led != 16'h0) lit++;
        end
        check_val("pwm_dark", 32'(lit), 32'd0);
`else
        lit = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
